// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM port between two requesters.
// Each grant runs a fixed IDLE -> ISSUE -> CAPTURE -> ACK sequence.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_CAPTURE = 2'b10,
        S_ACK     = 2'b11
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  grant_s;
    logic                  winner_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;

    logic                  owner_r;
    logic                  last_grant_r;
    logic                  op_we_r;
    logic                  ram_we_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0] ram_data_r;
    logic                  ack0_r;
    logic                  ack1_r;
    logic [DATA_WIDTH-1:0] rdata0_r;
    logic [DATA_WIDTH-1:0] rdata1_r;
    logic                  busy_r;

    // Next-state sequencing and round-robin winner selection
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        winner_s     = owner_r;
        case (state_r)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_s      = 1'b1;
                    state_next_s = S_ISSUE;
                    if (req0 && req1) begin
                        winner_s = ~last_grant_r;
                    end else if (req1) begin
                        winner_s = 1'b1;
                    end else begin
                        winner_s = 1'b0;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE:   state_next_s = S_CAPTURE;
            S_CAPTURE: state_next_s = S_ACK;
            S_ACK:     state_next_s = S_IDLE;
            default:   state_next_s = S_IDLE;
        endcase
    end

    // Route the winning requester's command fields
    always_comb begin
        if (winner_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant bookkeeping and RAM command latch; ram_we lives only for the ISSUE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            op_we_r      <= 1'b0;
            ram_we_r     <= 1'b0;
            ram_addr_r   <= {ADDR_WIDTH{1'b0}};
            ram_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            ram_we_r <= grant_s & sel_we_s;
            if (grant_s) begin
                owner_r      <= winner_s;
                last_grant_r <= winner_s;
                op_we_r      <= sel_we_s;
                ram_addr_r   <= sel_addr_s;
                ram_data_r   <= sel_wdata_s;
            end
        end
    end

    // Completion pulse, read capture and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            rdata0_r <= {DATA_WIDTH{1'b0}};
            rdata1_r <= {DATA_WIDTH{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            ack0_r <= (state_r == S_CAPTURE) && (owner_r == 1'b0);
            ack1_r <= (state_r == S_CAPTURE) && (owner_r == 1'b1);
            busy_r <= (state_next_s != S_IDLE);
            if ((state_r == S_CAPTURE) && !op_we_r) begin
                if (owner_r) begin
                    rdata1_r <= ram_q;
                end else begin
                    rdata0_r <= ram_q;
                end
            end
        end
    end

    assign ack0     = ack0_r;
    assign ack1     = ack1_r;
    assign rdata0   = rdata0_r;
    assign rdata1   = rdata1_r;
    assign ram_addr = ram_addr_r;
    assign ram_data = ram_data_r;
    assign ram_we   = ram_we_r;
    assign busy     = busy_r;
    assign owner    = owner_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized scoreboard bench for ram_port_arbiter with a transaction-level
// reference model (memory array, per-requester result, round-robin rule).
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [9:0]  ram_addr;
    logic [15:0] ram_data;
    logic        ram_we;
    logic [15:0] ram_q;
    logic        busy, owner;

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Physical RAM attached to the port
    logic [15:0] ram [1024];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_data;
        ram_q <= ram[ram_addr];
    end

    typedef struct {
        int          who;
        logic        we;
        logic [9:0]  addr;
        logic [15:0] r0;
        logic [15:0] r1;
    } exp_t;
    exp_t sb[$];

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_mem [1024];
    logic [15:0] ref_rdata [2];
    int          ref_lg;
    int          ack_cnt [2];

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ref_lg = 1;
        ref_rdata[0] = 16'h0000;
        ref_rdata[1] = 16'h0000;
    endfunction

    // One transaction completes for requester who, in grant order
    function automatic void model_txn(input int who, input logic we, input logic [9:0] a,
                                      input logic [15:0] d);
        exp_t e;
        if (we) ref_mem[a] = d;
        else ref_rdata[who] = ref_mem[a];
        ref_lg = who;
        e.who = who; e.we = we; e.addr = a; e.r0 = ref_rdata[0]; e.r1 = ref_rdata[1];
        sb.push_back(e);
    endfunction

    // Simultaneous requests: the one not granted last goes first
    function automatic void model_pair(input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                                       input logic w1, input logic [9:0] a1, input logic [15:0] d1);
        if (ref_lg == 1) begin
            model_txn(0, w0, a0, d0); model_txn(1, w1, a1, d1);
        end else begin
            model_txn(1, w1, a1, d1); model_txn(0, w0, a0, d0);
        end
    endfunction

    task automatic do_txn(input int who, input logic we, input logic [9:0] a, input logic [15:0] d);
        int n = 0;
        logic got;
        if (who == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
        else begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
        do begin
            @(posedge clk); #1; n++;
            got = (who == 0) ? ack0 : ack1;
        end while (!got && n < 40);
        check($sformatf("ack_timeout_req%0d", who), {31'd0, got}, 32'd1);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check(name, {ack0, ack1, rdata0, rdata1, ram_we, busy, owner}, 32'd0);
        check({name, "_ram"}, {6'd0, ram_addr, ram_data}, 32'd0);
    endtask

    task automatic async_reset();
        @(posedge clk); #3;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        #1 check_zero("async_reset");
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: pops the scoreboard on every ack and checks timing and results
    int cyc = 0, rise = 0, wecnt = 0;
    logic busy_q = 1'b0;
    always begin
        exp_t e;
        int   who;
        @(posedge clk); #1;
        cyc++;
        if (busy && !busy_q) begin rise = cyc; wecnt = 0; end
        busy_q = busy;
        if (ram_we) begin
            wecnt++;
            check("ram_we_window", cyc, rise);
        end
        if (ack0 && ack1) check("dual_ack", 32'd1, 32'd0);
        if (ack0 || ack1) begin
            who = ack1 ? 1 : 0;
            ack_cnt[who]++;
            if (sb.size() == 0) begin
                check("unexpected_ack", who, 32'hFFFF);
            end else begin
                e = sb.pop_front();
                check("ack_owner_line", who, e.who);
                check("owner", {31'd0, owner}, e.who);
                check("ack_latency", cyc - rise, 32'd2);
                check("ram_we_cycles", wecnt, {31'd0, e.we});
                check("ram_addr", {22'd0, ram_addr}, {22'd0, e.addr});
                check("rdata0", {16'd0, rdata0}, {16'd0, e.r0});
                check("rdata1", {16'd0, rdata1}, {16'd0, e.r1});
            end
        end
    end

    initial begin
        logic [9:0]  a0, a1;
        logic [15:0] d0, d1;
        logic        w0, w1;
        logic [9:0]  fa0 [4], fa1 [4];
        logic [15:0] fd0 [4], fd1 [4];
        logic        fw0 [4], fw1 [4];
        int          mode, c0, c1;

        for (int i = 0; i < 1024; i++) begin
            ram[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        model_reset();

        // Reset held for 3 cycles under random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = 10'($urandom); addr1 = 10'($urandom);
            wdata0 = 16'($urandom); wdata1 = 16'($urandom);
            @(posedge clk); #1;
        end
        check_zero("reset_hold");
        req0 = 1'b0; req1 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write then read by requester 0
        model_txn(0, 1'b1, 10'h012, 16'hBEEF);
        do_txn(0, 1'b1, 10'h012, 16'hBEEF);
        @(posedge clk); #1;
        model_txn(0, 1'b0, 10'h012, 16'h0000);
        do_txn(0, 1'b0, 10'h012, 16'h0000);
        check("rdata0_beef", {16'd0, rdata0}, 32'h0000BEEF);

        // Async reset clears outputs, then a tie resolves to requester 0
        async_reset();
        model_pair(1'b0, 10'h001, 16'h0000, 1'b0, 10'h002, 16'h0000);
        fork
            do_txn(0, 1'b0, 10'h001, 16'h0000);
            do_txn(1, 1'b0, 10'h002, 16'h0000);
        join
        @(posedge clk); #1;

        // Fairness: both re-request continuously for 8 transactions
        for (int k = 0; k < 4; k++) begin
            fw0[k] = 1'($urandom); fa0[k] = 10'($urandom); fd0[k] = 16'($urandom);
            fw1[k] = 1'($urandom); fa1[k] = 10'($urandom); fd1[k] = 16'($urandom);
        end
        for (int k = 0; k < 4; k++) model_pair(fw0[k], fa0[k], fd0[k], fw1[k], fa1[k], fd1[k]);
        c0 = ack_cnt[0]; c1 = ack_cnt[1];
        fork
            for (int k = 0; k < 4; k++) begin
                do_txn(0, fw0[k], fa0[k], fd0[k]);
                if (k < 3) begin @(posedge clk); @(posedge clk); #1; end
            end
            for (int j = 0; j < 4; j++) begin
                do_txn(1, fw1[j], fa1[j], fd1[j]);
                if (j < 3) begin @(posedge clk); @(posedge clk); #1; end
            end
        join
        @(posedge clk); #1;
        check("fair_ack0_count", ack_cnt[0] - c0, 32'd4);
        check("fair_ack1_count", ack_cnt[1] - c1, 32'd4);

        // Write isolation at the top address
        model_txn(1, 1'b1, 10'h3FF, 16'h1234);
        do_txn(1, 1'b1, 10'h3FF, 16'h1234);
        @(posedge clk); #1;
        model_txn(0, 1'b0, 10'h3FF, 16'h0000);
        do_txn(0, 1'b0, 10'h3FF, 16'h0000);
        check("rdata0_top", {16'd0, rdata0}, 32'h00001234);
        @(posedge clk); #1;

        // Randomized rounds over a small address window to force hits
        for (int r = 0; r < 30; r++) begin
            mode = $urandom_range(0, 2);
            w0 = 1'($urandom); a0 = {6'd0, 4'($urandom)}; d0 = 16'($urandom);
            w1 = 1'($urandom); a1 = {6'd0, 4'($urandom)}; d1 = 16'($urandom);
            case (mode)
                0: begin model_txn(0, w0, a0, d0); do_txn(0, w0, a0, d0); end
                1: begin model_txn(1, w1, a1, d1); do_txn(1, w1, a1, d1); end
                default: begin
                    model_pair(w0, a0, d0, w1, a1, d1);
                    fork
                        do_txn(0, w0, a0, d0);
                        do_txn(1, w1, a1, d1);
                    join
                end
            endcase
            @(posedge clk); #1;
        end

        // Reset during ISSUE aborts a write without committing it
        we1 = 1'b1; addr1 = 10'h020; wdata1 = 16'h5555; req1 = 1'b1;
        @(posedge clk); #1;
        check("midop_ram_we_issue", {31'd0, ram_we}, 32'd1);
        #2 rst_n = 1'b0; req1 = 1'b0;
        #1 check_zero("midop_reset");
        #2 rst_n = 1'b1;
        model_reset();
        repeat (6) @(posedge clk);
        #1;
        model_txn(0, 1'b0, 10'h020, 16'h0000);
        do_txn(0, 1'b0, 10'h020, 16'h0000);
        check("midop_not_committed", {16'd0, rdata0}, {16'd0, init_word(32)});

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares a single port of the dual-port data RAM (16-bit words, 10-bit address, one-cycle synchronous read) between the CPU load/store unit (requester 0) and a secondary master such as an I/O or DMA engine (requester 1). It uses a req/ack handshake, round-robin priority and a fixed four-state sequencer. Each transaction is issued to the RAM, the read word is captured, and the result is returned to its owner.

## Interface
Parameters:
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 10, RAM word address width

Ports:
- clk  input  1  single system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0 / req1  input  1  transaction request from requester 0 / 1
- we0 / we1  input  1  1 = write, 0 = read
- addr0 / addr1  input  ADDR_WIDTH  word address
- wdata0 / wdata1  input  DATA_WIDTH  write data
- ack0 / ack1  output  1  one-cycle completion pulse to owner
- rdata0 / rdata1  output  DATA_WIDTH  read result, registered
- ram_addr  output  ADDR_WIDTH  to RAM port address
- ram_data  output  DATA_WIDTH  to RAM port write data
- ram_we  output  1  to RAM port write enable
- ram_q  input  DATA_WIDTH  from RAM port read data, valid one cycle after address
- busy  output  1  high in any state other than IDLE
- owner  output  1  index of requester currently granted, holds last value in IDLE

## Operation
- Requesters assert req with we/addr/wdata and hold all of them stable until they see ack. They drop req in the cycle after ack.
- FSM states:
  - IDLE: if any req is high, pick a winner, register owner, latch winner's addr/we/wdata into ram_addr/ram_we/ram_data, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: ram_* are driven for exactly this cycle, and the RAM samples on the closing edge. Go to CAPTURE.
  - CAPTURE: ram_q is valid. On a read, the closing edge loads rdata[owner] from ram_q. On a write, rdata is untouched. ram_we is 0. Go to ACK.
  - ACK: ack[owner] = 1 for this cycle only. Go to IDLE.
- Arbitration is round-robin:
  - Only one req high: that requester wins.
  - Both high: the requester not granted last wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - last_grant updates in IDLE when a grant is made.
- Requests arriving while busy are not sampled until the next IDLE.
- A request dropped early, before ack, is completed anyway and acked. The RAM access has already committed.
- ram_we is high only in ISSUE and only for a write. It is never high in IDLE, CAPTURE or ACK.
- ram_addr/ram_data hold their last latched values outside ISSUE. The RAM ignores them because ram_we = 0.
- rdata0/rdata1 each hold their value until the next read completes for that same requester.
- addr wraps naturally at 2^ADDR_WIDTH. The arbiter performs no range check or decode.

## Timing
- Reset (async, immediate): state = IDLE, ack0 = ack1 = 0, rdata0 = rdata1 = 0, ram_addr = 0, ram_data = 0, ram_we = 0, busy = 0, owner = 0, last_grant = 1.
- Reset asserted mid-transaction aborts it: no ack is issued and ram_we drops immediately. A write aborted in ISSUE before the clock edge is not committed.
- Latency: req sampled high in IDLE at cycle N gives ISSUE at N+1, CAPTURE at N+2 and ACK at N+3. rdata is valid from N+3 onward.
- Throughput: one transaction per 4 cycles maximum. Back-to-back requests from both masters alternate with period 4.
- With both requesters continuously re-requesting, neither waits more than one transaction (4 cycles) beyond its own.
- busy is high during N+1..N+3 and low in IDLE.

## Test plan
- Reset values: hold rst_n = 0 for 3 cycles with random inputs, then release. All outputs are 0 and state is IDLE. Assert rst_n = 0 asynchronously between edges and outputs clear without waiting for a clock.
- Single write then read: req0 writes 0xBEEF to addr 0x012, then req0 reads 0x012. ram_we is high for exactly 1 cycle, ack0 pulses 3 cycles after each grant, and rdata0 = 0xBEEF. ack1 and rdata1 stay 0.
- Tie after reset: req0 and req1 are asserted in the same cycle, reading addresses 0x001 and 0x002. Requester 0 is granted first, ack0 at N+3, requester 1 granted at N+4, ack1 at N+7. Each rdata carries its own address's data.
- Round-robin fairness: both requesters re-request continuously for 8 transactions. owner alternates 0,1,0,1,... and ack0 and ack1 count 4 each.
- Write isolation: req1 writes 0x1234 to addr 0x3FF, the top address with no wrap fault. Then req0 reads 0x3FF, returns 0x1234, and rdata1 keeps its prior value.
- Reset mid-op: req1 writes 0x5555 to addr 0x020. Pulse rst_n low during ISSUE before the edge. No ack1, ram_we is 0, and a later read of 0x020 returns the original contents.
